rng_result_recorder: RTL and testbench
======================================

Name: rng_result_recorder

Overview:
- Consumer-side companion to the 4-bit LFSR random generator. It watches the generator's output bus while a roll is in progress and detects when the value has settled. It then commits the final rolled value into a small circular history buffer.
- The user can step back through earlier results with a recall key. The displayed value and index drive the seven-segment path.
- Sits between the generator output and the display decoder. It shares the generator's start key pulse.

Parameters:
DATA_W, 4, width of the random value
DEPTH, 4, history entries (power of two)
SETTLE_CYC, 50_000_000, consecutive unchanged cycles that mark a roll as finished (must exceed the generator's longest inter-update gap of 4*2^23 cycles)
CNT_W, 26, settle counter width (2^CNT_W > SETTLE_CYC)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  one-cycle start pulse, same pulse that drives the generator
i_value  in  DATA_W  generator random output
i_recall  in  1  one-cycle pulse, step to the next-older history entry
i_clear  in  1  one-cycle pulse, empty the history
o_value  out  DATA_W  value currently displayed
o_idx  out  log2(DEPTH)  age of the displayed entry (0 = newest)
o_count  out  log2(DEPTH)+1  number of valid entries, saturates at DEPTH
o_valid  out  1  o_value holds a committed result
o_busy  out  1  roll being tracked

Behaviour:
- Reset (async, i_rst=1):
  - Registers: state=S_IDLE, wr_ptr=0, last_r=0, settle counter=0.
  - Outputs: o_value=0, o_idx=0, o_count=0, o_valid=0, o_busy=0.
  - History contents are don't-care.
  - Reset asserted mid-roll abandons the roll; nothing is committed.
- All other logic is registered on posedge i_clk. Outputs come directly from registers.
- States:
  - S_IDLE: no roll in progress.
  - S_TRACK: roll in progress; o_busy=1 exactly while in this state.
- S_IDLE:
  - i_start: go to S_TRACK, counter=0, last_r=i_value.
  - i_recall with o_count>0: o_idx = (o_idx+1) wraps to 0 after o_count-1; o_value = entry at that age.
  - i_recall with o_count=0: ignored.
- S_TRACK:
  - Every cycle last_r<=i_value.
  - If i_value != last_r, counter=0; else counter increments.
  - Commit when i_value==last_r and counter==SETTLE_CYC-1, i.e. on the SETTLE_CYC-th consecutive equal sample.
  - Commit actions: hist[wr_ptr]=i_value; wr_ptr++ modulo DEPTH; o_count=min(o_count+1, DEPTH); o_value=i_value; o_idx=0; o_valid=1; state=S_IDLE. Outputs are visible the cycle after the commit edge.
  - i_recall is ignored in S_TRACK.
- i_start while in S_TRACK (generator already idle, new roll launched):
  - Force-commit the current i_value, which still holds the previous final value on that cycle.
  - Remain in S_TRACK with counter=0 and last_r=i_value.
- i_clear, any state:
  - o_count=0, wr_ptr=0, o_idx=0, o_valid=0, o_value=0, state=S_IDLE.
  - Highest priority: beats a same-cycle i_start, i_recall or commit.
- Full buffer: at o_count==DEPTH a commit overwrites the oldest entry; o_count stays DEPTH.
- Read addressing: entry of age k is hist[(wr_ptr-1-k) mod DEPTH].
- i_start and i_recall in the same S_IDLE cycle: start wins; recall is dropped.
- Pulses are single-cycle; held levels are not edge-detected here. Debouncing happens upstream.

Test Plan (SETTLE_CYC=8, CNT_W=4):
1. Reset pulse -> all outputs 0. Then i_start, i_value steps 15,7,3 with changes 3 cycles apart, then holds 3 -> o_busy=1 until the 8th equal sample. Then o_value=3, o_valid=1, o_count=1, o_idx=0, o_busy=0.
2. Four rolls settling on 9,4,12,6, then three i_recall pulses -> o_value 12,4,9 with o_idx 1,2,3. A fourth recall -> o_value=6, o_idx=0.
3. Fifth roll settling on 5 with DEPTH=4 -> o_count stays 4. Recall sequence yields 5,6,12,4 (9 overwritten).
4. Roll settling on 11 but i_start reasserted 2 cycles after the last change -> 11 committed immediately. o_busy stays 1; the next roll tracked from counter 0.
5. i_clear same cycle as i_start and a pending commit -> o_count=0, o_valid=0, o_value=0, state idle (o_busy=0). A later i_recall is ignored.
6. i_rst asserted asynchronously mid-roll, between clock edges -> outputs 0 immediately, no commit. After release, history empty (o_count=0).

Source files
------------

// File: rtl/rng_result_recorder.sv
// Watches the LFSR generator output during a roll and commits the settled value
// into a small circular history that can be stepped through for display.
module rng_result_recorder #(
    parameter int DATA_W     = 4,
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 50_000_000,
    parameter int CNT_W      = 26
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [DATA_W-1:0]          i_value,
    input  logic                       i_recall,
    input  logic                       i_clear,
    output logic [DATA_W-1:0]          o_value,
    output logic [$clog2(DEPTH)-1:0]   o_idx,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_valid,
    output logic                       o_busy
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   wr_ptr, wr_ptr_n;
    logic [DATA_W-1:0]  last_r, last_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DATA_W-1:0]  value_n;
    logic [IDX_W-1:0]   idx_n;
    logic [IDX_W:0]     count_n;
    logic               valid_n;
    logic               commit;

    logic [DATA_W-1:0]  hist [DEPTH];

    logic [IDX_W:0]     idx_inc;
    logic [IDX_W-1:0]   recall_idx;
    logic [IDX_W-1:0]   rd_addr;

    // Next-older entry, wrapping back to the newest after the oldest valid one.
    assign idx_inc    = {1'b0, o_idx} + (IDX_W+1)'(1);
    assign recall_idx = (idx_inc == o_count) ? '0 : idx_inc[IDX_W-1:0];
    assign rd_addr    = wr_ptr - IDX_W'(1) - recall_idx;

    assign o_busy = (state == S_TRACK);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        last_n   = last_r;
        cnt_n    = cnt;
        value_n  = o_value;
        idx_n    = o_idx;
        count_n  = o_count;
        valid_n  = o_valid;
        commit   = 1'b0;

        if (i_clear) begin
            state_n  = S_IDLE;
            wr_ptr_n = '0;
            cnt_n    = '0;
            value_n  = '0;
            idx_n    = '0;
            count_n  = '0;
            valid_n  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state_n = S_TRACK;
                        cnt_n   = '0;
                        last_n  = i_value;
                    end else if (i_recall && (o_count != '0)) begin
                        idx_n   = recall_idx;
                        value_n = hist[rd_addr];
                    end
                end
                S_TRACK: begin
                    last_n = i_value;
                    // A new start means the generator already stopped: its output is final.
                    if (i_start) begin
                        commit = 1'b1;
                        cnt_n  = '0;
                    end else if (i_value != last_r) begin
                        cnt_n = '0;
                    end else if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        commit  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        if (commit) begin
            wr_ptr_n = wr_ptr + IDX_W'(1);
            count_n  = (o_count == (IDX_W+1)'(DEPTH)) ? o_count : o_count + (IDX_W+1)'(1);
            value_n  = i_value;
            idx_n    = '0;
            valid_n  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            last_r  <= '0;
            cnt     <= '0;
            o_value <= '0;
            o_idx   <= '0;
            o_count <= '0;
            o_valid <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            last_r  <= last_n;
            cnt     <= cnt_n;
            o_value <= value_n;
            o_idx   <= idx_n;
            o_count <= count_n;
            o_valid <= valid_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (commit) hist[wr_ptr] <= i_value;
    end

endmodule

// File: tb/tb_rng_result_recorder.sv
// Bench for rng_result_recorder: queue-based history model checked every cycle,
// plus directed rolls/recalls with hand-computed literal expectations.
module tb_rng_result_recorder;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 8;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_start = 1'b0;
    logic [DATA_W-1:0] i_value = '0;
    logic              i_recall = 1'b0;
    logic              i_clear = 1'b0;
    logic [DATA_W-1:0] o_value;
    logic [1:0]        o_idx;
    logic [2:0]        o_count;
    logic              o_valid;
    logic              o_busy;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    rng_result_recorder #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .SETTLE_CYC(SETTLE), .CNT_W(4)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_value(i_value),
        .i_recall(i_recall), .i_clear(i_clear), .o_value(o_value), .o_idx(o_idx),
        .o_count(o_count), .o_valid(o_valid), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Model: history as a queue with the newest result at the front.
    int hq[$];
    int m_age = 0;
    bit m_busy = 0;
    bit m_valid = 0;
    int prev = 0;
    int run = 0;

    function automatic void push(int v);
        hq.push_front(v);
        if (hq.size() > DEPTH) void'(hq.pop_back());
        m_age = 0;
        m_valid = 1;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hq.delete(); m_busy = 0; m_age = 0; m_valid = 0; prev = 0; run = 0;
        end else if (i_clear) begin
            hq.delete(); m_busy = 0; m_age = 0; m_valid = 0;
        end else if (!m_busy) begin
            if (i_start) begin
                m_busy = 1; prev = int'(i_value); run = 0;
            end else if (i_recall && hq.size() > 0) begin
                m_age = (m_age + 1) % hq.size();
            end
        end else begin
            if (i_start) begin
                push(int'(i_value)); run = 0;
            end else if (int'(i_value) == prev) begin
                run++;
                if (run == SETTLE) begin
                    push(int'(i_value)); m_busy = 0;
                end
            end else begin
                run = 0;
            end
            prev = int'(i_value);
        end
    end

    function automatic int m_value();
        return (hq.size() > 0) ? hq[m_age] : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (cmp_en) begin
            chk("cyc_value", int'(o_value), m_value());
            chk("cyc_idx",   int'(o_idx),   m_age);
            chk("cyc_count", int'(o_count), hq.size());
            chk("cyc_valid", int'(o_valid), int'(m_valid));
            chk("cyc_busy",  int'(o_busy),  int'(m_busy));
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (o_busy && n < 40) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(o_busy), 0);
    endtask

    task automatic roll(input logic [3:0] v0, input logic [3:0] fin, output int n);
        i_start = 1; i_value = v0;
        tick();
        i_start = 0; i_value = fin;
        wait_idle(n);
    endtask

    task automatic recall(input int exp_v, input int exp_i);
        i_recall = 1;
        tick();
        i_recall = 0;
        chk("recall_value", int'(o_value), exp_v);
        chk("recall_idx", int'(o_idx), exp_i);
    endtask

    int n;

    initial begin
        // 1: reset, then a roll with intermediate values settling on 3
        i_rst = 1;
        #12;
        chk("rst_value", int'(o_value), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_busy", int'(o_busy), 0);
        i_rst = 0;
        cmp_en = 1;
        tick();
        i_start = 1; i_value = 15;
        tick();
        i_start = 0;
        tick(); tick();
        i_value = 7;
        tick(); tick(); tick();
        i_value = 3;
        wait_idle(n);
        chk("t1_settle_cycles", n, 9);
        chk("t1_value", int'(o_value), 3);
        chk("t1_valid", int'(o_valid), 1);
        chk("t1_count", int'(o_count), 1);
        chk("t1_idx", int'(o_idx), 0);

        // 2: four rolls, recall walks back and wraps
        roll(4'd1, 4'd9, n);
        roll(4'd1, 4'd4, n);
        roll(4'd1, 4'd12, n);
        roll(4'd1, 4'd6, n);
        chk("t2_settle_cycles", n, 9);
        chk("t2_count", int'(o_count), 4);
        recall(12, 1);
        recall(4, 2);
        recall(9, 3);
        recall(6, 0);

        // 3: fifth roll overwrites the oldest entry
        roll(4'd1, 4'd5, n);
        chk("t3_count", int'(o_count), 4);
        chk("t3_value", int'(o_value), 5);
        recall(6, 1);
        recall(12, 2);
        recall(4, 3);
        recall(5, 0);

        // 4: restart two cycles after the last change forces a commit of 11
        i_start = 1; i_value = 2;
        tick();
        i_start = 0; i_value = 11;
        tick(); tick();
        i_start = 1;
        tick();
        i_start = 0;
        chk("t4_force_value", int'(o_value), 11);
        chk("t4_force_busy", int'(o_busy), 1);
        chk("t4_force_count", int'(o_count), 4);
        repeat (7) tick();
        chk("t4_still_busy", int'(o_busy), 1);
        tick();
        chk("t4_settled_busy", int'(o_busy), 0);
        chk("t4_settled_value", int'(o_value), 11);
        recall(11, 1);
        recall(5, 2);

        // 5: clear beats a same-cycle start and a pending commit
        i_start = 1; i_value = 1;
        tick();
        i_start = 0; i_value = 8;
        repeat (8) tick();
        chk("t5_pending_busy", int'(o_busy), 1);
        i_clear = 1; i_start = 1;
        tick();
        i_clear = 0; i_start = 0;
        chk("t5_count", int'(o_count), 0);
        chk("t5_valid", int'(o_valid), 0);
        chk("t5_value", int'(o_value), 0);
        chk("t5_busy", int'(o_busy), 0);
        recall(0, 0);
        chk("t5_recall_count", int'(o_count), 0);

        // 6: async reset mid-roll drops the roll and the history
        roll(4'd1, 4'd10, n);
        chk("t6_pre_count", int'(o_count), 1);
        i_start = 1; i_value = 3;
        tick();
        i_start = 0; i_value = 13;
        repeat (8) tick();
        #2;
        i_rst = 1;
        #1;
        chk("t6_rst_value", int'(o_value), 0);
        chk("t6_rst_busy", int'(o_busy), 0);
        chk("t6_rst_valid", int'(o_valid), 0);
        @(posedge i_clk);
        #2;
        i_rst = 0;
        tick(); tick();
        chk("t6_count", int'(o_count), 0);
        chk("t6_busy", int'(o_busy), 0);
        chk("t6_value", int'(o_value), 0);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
